// File: rtl/vga_timing_pkg.sv
// Shared raster-timing constants and helpers for the VGA timing generator.
package vga_timing_pkg;

  // 640x480@60 default segment widths.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Total positions along one axis (HMAX or VMAX).
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True when count lies in [start, start+len-1].
  function automatic logic in_window(input int unsigned count,
                                     input int unsigned start,
                                     input int unsigned len);
    return (count >= start) && (count < start + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control and timing bundle between the raster generator (master) and its
// consumers (slave): pixel enable / restart inward, position and strobes outward.
interface vga_timing_if #(
  parameter int unsigned HW  = 10,
  parameter int unsigned VW  = 10,
  parameter int unsigned FCW = 8
);
  logic           pix_en;
  logic           restart;
  logic [HW-1:0]  h_count;
  logic [VW-1:0]  v_count;
  logic           hsync;
  logic           vsync;
  logic           active;
  logic           line_end;
  logic           frame_start;
  logic           frame_end;
  logic [FCW-1:0] frame_count;

  modport master (
    input  pix_en, restart,
    output h_count, v_count, hsync, vsync, active,
           line_end, frame_start, frame_end, frame_count
  );

  modport slave (
    output pix_en, restart,
    input  h_count, v_count, hsync, vsync, active,
           line_end, frame_start, frame_end, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// Modulo-MAX position counter for one raster axis.
// Ports: i_Clk, i_Rst_n (async active-low), i_En (advance), i_Clr (sync clear,
// wins over i_En), o_Count (registered), o_Next (next-state count),
// o_Wrap (count sits on its last value).
module axis_counter #(
  parameter int unsigned MAX = 800,
  parameter int unsigned W   = $clog2(MAX)
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_En,
  input  logic         i_Clr,
  output logic [W-1:0] o_Count,
  output logic [W-1:0] o_Next,
  output logic         o_Wrap
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: clear, advance with wrap, or hold.
  always_comb begin
    count_d = count_q;
    if (i_Clr) begin
      count_d = '0;
    end else if (i_En) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign o_Count = count_q;
  assign o_Next  = count_d;
  assign o_Wrap  = (count_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Ports: i_Clk, i_Rst_n (async active-low), i_Pix_En (advance), i_Restart
// (sync return to (0,0)), o_H_count/o_V_count (position), o_HSync/o_VSync,
// o_Active, o_Line_end, o_Frame_start, o_Frame_end, o_Frame_count.
// All outputs are registered from next-state counts so they align with the
// position they describe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
  parameter int unsigned H_FP             = DEF_H_FP,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BP             = DEF_H_BP,
  parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
  parameter int unsigned V_FP             = DEF_V_FP,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BP             = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter int unsigned FRAME_CNT_W      = 8,
  localparam int unsigned HMAX = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned VMAX = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW   = $clog2(HMAX),
  localparam int unsigned VW   = $clog2(VMAX)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Pix_En,
  input  logic                   i_Restart,
  output logic [HW-1:0]          o_H_count,
  output logic [VW-1:0]          o_V_count,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic                   o_Line_end,
  output logic                   o_Frame_start,
  output logic                   o_Frame_end,
  output logic [FRAME_CNT_W-1:0] o_Frame_count
);
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_CNT_W < 1) begin : g_bad_params
    $error("vga_timing_gen: every segment width and FRAME_CNT_W must be at least 1");
  end

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          h_wrap, v_wrap, v_en;

  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   active_q, active_d, line_end_q, line_end_d;
  logic                   fstart_q, fstart_d, fend_q, fend_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   hs_on, vs_on;

  axis_counter #(.MAX(HMAX), .W(HW)) u_h_cnt (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_En    (i_Pix_En),
    .i_Clr   (i_Restart),
    .o_Count (o_H_count),
    .o_Next  (h_next),
    .o_Wrap  (h_wrap)
  );

  // Vertical axis steps only on the enabled last pixel of a line.
  assign v_en = i_Pix_En & h_wrap;

  axis_counter #(.MAX(VMAX), .W(VW)) u_v_cnt (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_En    (v_en),
    .i_Clr   (i_Restart),
    .o_Count (o_V_count),
    .o_Next  (v_next),
    .o_Wrap  (v_wrap)
  );

  // Decode strobes for the position the counters move to.
  always_comb begin
    hs_on      = in_window(32'(h_next), H_ACTIVE + H_FP, H_SYNC);
    vs_on      = in_window(32'(v_next), V_ACTIVE + V_FP, V_SYNC);
    hsync_d    = SYNC_ACTIVE_HIGH ? hs_on : ~hs_on;
    vsync_d    = SYNC_ACTIVE_HIGH ? vs_on : ~vs_on;
    active_d   = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
    line_end_d = (h_next == HW'(HMAX - 1));
    fstart_d   = (h_next == '0) && (v_next == '0);
    fend_d     = line_end_d && (v_next == VW'(VMAX - 1));
    fcnt_d     = fcnt_q;
    // A restart abandons the frame, so it never counts as completed.
    if (!i_Restart && v_en && v_wrap) begin
      fcnt_d = fcnt_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_q    <= SYNC_IDLE;
      vsync_q    <= SYNC_IDLE;
      active_q   <= 1'b1;
      line_end_q <= 1'b0;
      fstart_q   <= 1'b1;
      fend_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      active_q   <= active_d;
      line_end_q <= line_end_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Line_end    = line_end_q;
  assign o_Frame_start = fstart_q;
  assign o_Frame_end   = fend_q;
  assign o_Frame_count = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 active-low,
// tiny 8x5 active-high, medium 20x15 active-low) share clock, reset, enable
// and restart, and are compared against a position-index reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  vga_timing_if #(.HW(10), .VW(10), .FCW(8)) if0 ();
  vga_timing_if #(.HW(3),  .VW(3),  .FCW(8)) if1 ();
  vga_timing_if #(.HW(5),  .VW(4),  .FCW(8)) if2 ();

  assign if0.pix_en = pix_en;  assign if0.restart = restart;
  assign if1.pix_en = pix_en;  assign if1.restart = restart;
  assign if2.pix_en = pix_en;  assign if2.restart = restart;

  vga_timing_gen u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(if0.pix_en), .i_Restart(if0.restart),
    .o_H_count(if0.h_count), .o_V_count(if0.v_count), .o_HSync(if0.hsync),
    .o_VSync(if0.vsync), .o_Active(if0.active), .o_Line_end(if0.line_end),
    .o_Frame_start(if0.frame_start), .o_Frame_end(if0.frame_end),
    .o_Frame_count(if0.frame_count)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_HIGH(1'b1)
  ) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(if1.pix_en), .i_Restart(if1.restart),
    .o_H_count(if1.h_count), .o_V_count(if1.v_count), .o_HSync(if1.hsync),
    .o_VSync(if1.vsync), .o_Active(if1.active), .o_Line_end(if1.line_end),
    .o_Frame_start(if1.frame_start), .o_Frame_end(if1.frame_end),
    .o_Frame_count(if1.frame_count)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE_HIGH(1'b0)
  ) u_dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(if2.pix_en), .i_Restart(if2.restart),
    .o_H_count(if2.h_count), .o_V_count(if2.v_count), .o_HSync(if2.hsync),
    .o_VSync(if2.vsync), .o_Active(if2.active), .o_Line_end(if2.line_end),
    .o_Frame_start(if2.frame_start), .o_Frame_end(if2.frame_end),
    .o_Frame_count(if2.frame_count)
  );

  // Observed outputs; flags packed as {hsync, vsync, active, line_end, frame_start, frame_end}.
  logic [31:0] obs_h [3];
  logic [31:0] obs_v [3];
  logic [31:0] obs_fc [3];
  logic [5:0]  obs_fl [3];

  assign obs_h[0] = 32'(if0.h_count);  assign obs_v[0] = 32'(if0.v_count);
  assign obs_h[1] = 32'(if1.h_count);  assign obs_v[1] = 32'(if1.v_count);
  assign obs_h[2] = 32'(if2.h_count);  assign obs_v[2] = 32'(if2.v_count);
  assign obs_fc[0] = 32'(if0.frame_count);
  assign obs_fc[1] = 32'(if1.frame_count);
  assign obs_fc[2] = 32'(if2.frame_count);
  assign obs_fl[0] = {if0.hsync, if0.vsync, if0.active, if0.line_end, if0.frame_start, if0.frame_end};
  assign obs_fl[1] = {if1.hsync, if1.vsync, if1.active, if1.line_end, if1.frame_start, if1.frame_end};
  assign obs_fl[2] = {if2.hsync, if2.vsync, if2.active, if2.line_end, if2.frame_start, if2.frame_end};

  // Per-instance configuration.
  int unsigned HA [3] = '{640, 4, 10};
  int unsigned HF [3] = '{16, 1, 2};
  int unsigned HS [3] = '{96, 2, 3};
  int unsigned HB [3] = '{48, 1, 5};
  int unsigned VA [3] = '{480, 2, 8};
  int unsigned VF [3] = '{10, 1, 2};
  int unsigned VS [3] = '{2, 1, 2};
  int unsigned VB [3] = '{33, 1, 3};
  bit          SAH [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: enabled-cycle index within the frame, and completed frames.
  int unsigned k [3] = '{0, 0, 0};
  int unsigned fc [3] = '{0, 0, 0};

  function automatic int unsigned hmax(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int unsigned vmax(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic int unsigned exp_h(input int i);
    return k[i] % hmax(i);
  endfunction

  function automatic int unsigned exp_v(input int i);
    return k[i] / hmax(i);
  endfunction

  function automatic logic [5:0] exp_flags(input int i);
    int unsigned h, v;
    logic hs_on, vs_on;
    h = exp_h(i);
    v = exp_v(i);
    hs_on = (h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]);
    vs_on = (v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]);
    return {SAH[i] ? hs_on : !hs_on, SAH[i] ? vs_on : !vs_on,
            (h < HA[i]) && (v < VA[i]), h == hmax(i) - 1,
            k[i] == 0, k[i] == hmax(i) * vmax(i) - 1};
  endfunction

  // One clock: model follows the inputs seen at the edge; returns at the negedge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || restart) begin
        k[i] = 0;
        if (!rst_n) fc[i] = 0;
      end else if (pix_en) begin
        k[i]++;
        if (k[i] == hmax(i) * vmax(i)) begin
          k[i] = 0;
          fc[i] = (fc[i] + 1) % 256;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_h[i] !== 0 || obs_v[i] !== 0 || obs_fc[i] !== 0) begin
        miscompares++;
        $display("FAIL reset_counts inst%0d: got h=%0d v=%0d fc=%0d want 0/0/0",
                 i, obs_h[i], obs_v[i], obs_fc[i]);
      end
      vectors++;
      if (obs_fl[i] !== exp_flags(i)) begin
        miscompares++;
        $display("FAIL reset_flags inst%0d: got %b want %b", i, obs_fl[i], exp_flags(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_line();
    int act_cnt = 0;
    pix_en = 1'b1;
    for (int n = 1; n <= 1700; n++) begin
      tick();
      if (n <= 800 && obs_fl[0][3]) act_cnt++;
      vectors++;
      if (obs_h[0] !== exp_h(0) || obs_v[0] !== exp_v(0) || obs_fl[0] !== exp_flags(0)) begin
        miscompares++;
        $display("FAIL line inst0 n=%0d: got h=%0d v=%0d fl=%b want h=%0d v=%0d fl=%b",
                 n, obs_h[0], obs_v[0], obs_fl[0], exp_h(0), exp_v(0), exp_flags(0));
      end
    end
    vectors++;
    if (act_cnt != 640) begin
      miscompares++;
      $display("FAIL line_active_count: got %0d want 640", act_cnt);
    end
  endtask

  task automatic test_small_frame();
    logic [7:0] hs_pat;
    int fe_seen = 0;
    int unsigned fc_before;
    pix_en = 1'b1;
    do_restart();
    fc_before = fc[1];
    hs_pat = '0;
    hs_pat[0] = obs_fl[1][5];
    for (int n = 1; n < 40; n++) begin
      tick();
      if (n < 8) hs_pat[n] = obs_fl[1][5];
      if (obs_fl[1][0]) fe_seen++;
    end
    vectors++;
    if (hs_pat !== 8'b0110_0000) begin
      miscompares++;
      $display("FAIL small_hsync_window: got %b want 01100000", hs_pat);
    end
    vectors++;
    if (obs_fl[1][0] !== 1'b1 || fe_seen != 1) begin
      miscompares++;
      $display("FAIL small_frame_end: got fe=%b seen=%0d want 1/1", obs_fl[1][0], fe_seen);
    end
    tick();
    vectors++;
    if (obs_h[1] !== 0 || obs_v[1] !== 0 || obs_fl[1][1] !== 1'b1 ||
        obs_fc[1] !== (fc_before + 1) % 256) begin
      miscompares++;
      $display("FAIL small_wrap: got h=%0d v=%0d fs=%b fc=%0d want 0/0/1/%0d",
               obs_h[1], obs_v[1], obs_fl[1][1], obs_fc[1], (fc_before + 1) % 256);
    end
  endtask

  task automatic test_restart_on_frame_end();
    int unsigned fc_before;
    pix_en = 1'b1;
    do_restart();
    repeat (39) tick();
    fc_before = fc[1];
    vectors++;
    if (obs_fl[1][0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rfe_setup: got fe=%b want 1", obs_fl[1][0]);
    end
    do_restart();
    vectors++;
    if (obs_fc[1] !== fc_before || obs_fl[1][1] !== 1'b1 || obs_h[1] !== 0) begin
      miscompares++;
      $display("FAIL restart_on_frame_end: got fc=%0d fs=%b h=%0d want %0d/1/0",
               obs_fc[1], obs_fl[1][1], obs_h[1], fc_before);
    end
  endtask

  task automatic test_pix_en_half();
    int unsigned fc_before;
    int clocks = -1;
    pix_en = 1'b1;
    do_restart();
    fc_before = fc[1];
    for (int n = 1; n <= 200; n++) begin
      pix_en = (n % 2 == 0);
      tick();
      vectors++;
      if (obs_h[1] !== exp_h(1) || obs_v[1] !== exp_v(1) || obs_fl[1] !== exp_flags(1)) begin
        miscompares++;
        $display("FAIL half_en_hold n=%0d: got h=%0d v=%0d fl=%b want h=%0d v=%0d fl=%b",
                 n, obs_h[1], obs_v[1], obs_fl[1], exp_h(1), exp_v(1), exp_flags(1));
      end
      if (clocks < 0 && obs_fc[1] !== fc_before) clocks = n;
    end
    vectors++;
    if (clocks != 80) begin
      miscompares++;
      $display("FAIL half_en_frame_clocks: got %0d want 80", clocks);
    end
  endtask

  task automatic test_restart();
    pix_en = 1'b1;
    do_restart();
    repeat (157) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_h[i] !== 0 || obs_v[i] !== 0 || obs_fl[i][1] !== 1'b1 || obs_fc[i] !== fc[i]) begin
        miscompares++;
        $display("FAIL restart inst%0d: got h=%0d v=%0d fs=%b fc=%0d want 0/0/1/%0d",
                 i, obs_h[i], obs_v[i], obs_fl[i][1], obs_fc[i], fc[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      pix_en  = 1'($urandom_range(1, 0));
      restart = ($urandom_range(149, 0) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_h[i] !== exp_h(i) || obs_v[i] !== exp_v(i) ||
            obs_fl[i] !== exp_flags(i) || obs_fc[i] !== fc[i]) begin
          miscompares++;
          $display("FAIL random inst%0d n=%0d: got h=%0d v=%0d fl=%b fc=%0d want h=%0d v=%0d fl=%b fc=%0d",
                   i, n, obs_h[i], obs_v[i], obs_fl[i], obs_fc[i],
                   exp_h(i), exp_v(i), exp_flags(i), fc[i]);
        end
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_async_reset();
    pix_en = 1'b1;
    do_restart();
    repeat (700) tick();
    vectors++;
    if (obs_fl[0][5] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_setup_hsync: got %b want 0", obs_fl[0][5]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_fl[0][5] !== 1'b1) begin
      miscompares++;
      $display("FAIL async_hsync_idle: got %b want 1", obs_fl[0][5]);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_h[i] !== 0 || obs_v[i] !== 0 || obs_fc[i] !== 0) begin
        miscompares++;
        $display("FAIL async_counts inst%0d: got h=%0d v=%0d fc=%0d want 0/0/0",
                 i, obs_h[i], obs_v[i], obs_fc[i]);
      end
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_line();
    test_small_frame();
    test_restart_on_frame_end();
    test_pix_en_half();
    test_restart();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
